// File: rtl/capture_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : capture_scheduler
// Description : Sequences multi-batch captures from a framed input buffer.
//               A capture is: one buf_reset pulse (ARM), a wait for the
//               buffer's first start-of-packet (FILL, guarded by a timeout),
//               then RUNS batches delimited by buf_eop (STREAM). In
//               continuous mode a HOLDOFF-cycle gap (HOLD) separates
//               consecutive captures.
//
// Ports       : sink_clk      - single clock, shared with the buffer source
//               reset         - synchronous, active-high
//               enable        - continuous capture; low stops after current
//               trigger       - single-cycle request for one capture (IDLE)
//               buf_reset     - one-cycle pulse restarting buffer loading
//               buf_sop/eop/valid - buffer output framing
//               busy          - high whenever not IDLE
//               done          - one-cycle pulse on capture completion
//                               (asserted in the cycle of the final eop)
//               batch_idx     - index of the current or last batch
//               capture_count - completed captures, wraps 65535 -> 0
//               error         - sticky fault flag, cleared only by reset
//
// Options     : define CAPTURE_SCHEDULER_CHECK_EN to compile in the STREAM
//               framing checker (valid gaps inside a batch, sop inside an
//               open batch, eop outside a batch all raise error).
//
// Revision    : 1.0 - initial release
// ============================================================================
module capture_scheduler #(
    parameter int BATCH_SIZE = 2048,
    parameter int RUNS       = 3,
    parameter int HOLDOFF    = 4096,
    parameter int TIMEOUT    = 8192
) (
    input  logic                                      sink_clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic                                      trigger,
    output logic                                      buf_reset,
    input  logic                                      buf_sop,
    input  logic                                      buf_eop,
    input  logic                                      buf_valid,
    output logic                                      busy,
    output logic                                      done,
    output logic [((RUNS > 1) ? $clog2(RUNS) : 1)-1:0] batch_idx,
    output logic [15:0]                               capture_count,
    output logic                                      error
);

    localparam int c_IDX_W = (RUNS > 1) ? $clog2(RUNS) : 1;
    localparam int c_TMAX  = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
    localparam int c_TMR_W = $clog2(c_TMAX + 1);

    localparam logic [c_IDX_W-1:0] c_LAST_IDX     = c_IDX_W'(RUNS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE      = c_IDX_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE      = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST    = c_TMR_W'(HOLDOFF - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ARM    = 3'd1;
    localparam logic [2:0] c_ST_FILL   = 3'd2;
    localparam logic [2:0] c_ST_STREAM = 3'd3;
    localparam logic [2:0] c_ST_HOLD   = 3'd4;

    // Elaboration-time parameter sanity checks.
    generate
        if (TIMEOUT <= BATCH_SIZE + RUNS) begin : g_bad_timeout
            $error("capture_scheduler: TIMEOUT must exceed BATCH_SIZE+RUNS");
        end
        if ((HOLDOFF < 1) || (HOLDOFF > 65535)) begin : g_bad_holdoff
            $error("capture_scheduler: HOLDOFF must be in 1..65535");
        end
    endgenerate

    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_IDX_W-1:0] r_batch_idx;
    logic [15:0]        r_count;
    logic               r_error;

    logic [2:0]         w_state_nxt;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [15:0]        w_count_nxt;
    logic               w_error_nxt;
    logic               w_done;
    logic               w_proto_err;
    logic               w_batch_end;

`ifdef CAPTURE_SCHEDULER_CHECK_EN
    logic r_open;
    logic w_open_nxt;
`endif

    always_ff @(posedge sink_clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_batch_idx <= '0;
            r_count     <= '0;
            r_error     <= 1'b0;
`ifdef CAPTURE_SCHEDULER_CHECK_EN
            r_open      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_batch_idx <= w_idx_nxt;
            r_count     <= w_count_nxt;
            r_error     <= w_error_nxt;
`ifdef CAPTURE_SCHEDULER_CHECK_EN
            r_open      <= w_open_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_batch_idx;
        w_count_nxt = r_count;
        w_error_nxt = r_error;
        w_done      = 1'b0;
        w_proto_err = 1'b0;
`ifdef CAPTURE_SCHEDULER_CHECK_EN
        w_open_nxt  = r_open;
        // A one-entry batch carries sop and eop on the same beat, so an eop
        // accompanied by sop is not "outside a batch".
        w_proto_err = (r_state == c_ST_STREAM) &&
                      ((r_open && !buf_valid) ||
                       (buf_valid && buf_sop && r_open) ||
                       (buf_valid && buf_eop && !r_open && !buf_sop));
`endif
        w_batch_end = (r_state == c_ST_STREAM) && buf_eop && buf_valid && !w_proto_err;

        case (r_state)
            c_ST_IDLE: begin
                if ((trigger || enable) && !r_error) begin
                    w_state_nxt = c_ST_ARM;
                end
            end
            c_ST_ARM: begin
                w_idx_nxt   = '0;
                w_timer_nxt = '0;
                w_state_nxt = c_ST_FILL;
            end
            c_ST_FILL: begin
                // The sop beat opens batch 0; first-beat eop is not expected
                // since a batch holds BATCH_SIZE entries.
                if (buf_sop && buf_valid) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_STREAM;
`ifdef CAPTURE_SCHEDULER_CHECK_EN
                    w_open_nxt  = 1'b1;
`endif
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            c_ST_STREAM: begin
                if (w_proto_err) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_ST_IDLE;
`ifdef CAPTURE_SCHEDULER_CHECK_EN
                    w_open_nxt  = 1'b0;
`endif
                end else begin
`ifdef CAPTURE_SCHEDULER_CHECK_EN
                    if (buf_valid && buf_sop) begin
                        w_open_nxt = 1'b1;
                    end
                    if (w_batch_end) begin
                        w_open_nxt = 1'b0;
                    end
`endif
                    if (w_batch_end) begin
                        if (r_batch_idx != c_LAST_IDX) begin
                            w_idx_nxt = r_batch_idx + c_IDX_ONE;
                        end else begin
                            w_done      = 1'b1;
                            w_count_nxt = r_count + 16'd1;
                            w_timer_nxt = '0;
                            w_state_nxt = enable ? c_ST_HOLD : c_ST_IDLE;
                        end
                    end
                end
            end
            c_ST_HOLD: begin
                // Enable is only consulted on the last HOLD cycle, so a
                // falling enable never shortens the holdoff.
                if (r_timer == c_HOLD_LAST) begin
                    w_state_nxt = enable ? c_ST_ARM : c_ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Pulses are gated by reset so that a reset cycle never shows a
    // buf_reset or done pulse.
    assign buf_reset     = (r_state == c_ST_ARM) && !reset;
    assign done          = w_done && !reset;
    assign busy          = (r_state != c_ST_IDLE);
    assign batch_idx     = r_batch_idx;
    assign capture_count = r_count;
    assign error         = r_error;

endmodule
`default_nettype wire
